// File: rtl/hex_ascii_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : hex_ascii_tx_encoder
// Purpose  : Serialises a binary word as ASCII hex characters, MSB nibble
//            first, one character per valid/ready handshake on a byte stream.
//            Optional CR/LF word terminator when HEX_TX_CRLF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module hex_ascii_tx_encoder #(
  parameter int DATA_WIDTH = 16,
  parameter bit UPPER_CASE = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  iVALID,
  input  logic [DATA_WIDTH-1:0] iD,
  output logic                  oREADY,
  output logic                  oVALID,
  output logic [7:0]            oD,
  input  logic                  iREADY,
  output logic                  oBUSY
);

  localparam int NUM_DIGITS = (DATA_WIDTH + 3) / 4;
  localparam int SHIFT_W    = NUM_DIGITS * 4;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_digit = 2'd1;
`ifdef HEX_TX_CRLF_EN
  localparam logic [1:0] c_st_cr    = 2'd2;
  localparam logic [1:0] c_st_lf    = 2'd3;
`endif

  localparam logic [7:0] c_alpha_base = UPPER_CASE ? 8'h41 : 8'h61;

  // Nibble to ASCII hex digit; 8-bit arithmetic never overflows here.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return c_alpha_base + {4'h0, n} - 8'd10;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [SHIFT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [7:0]         char_q,  char_d;
  logic               valid_q, valid_d;

  logic               w_accept;
  logic               w_xfer;
  logic               w_last;
  logic [SHIFT_W-1:0] w_ext;
  logic [SHIFT_W-1:0] w_shifted;

  assign w_accept  = iVALID && (state_q == c_st_idle);
  assign w_xfer    = valid_q && iREADY;
  assign w_last    = (cnt_q == '0);
  assign w_ext     = SHIFT_W'(iD);
  assign w_shifted = shreg_q << 4;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= c_st_idle;
      shreg_q <= '0;
      cnt_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: advance only on accepted words or completed transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (w_accept) state_d = c_st_digit;
`ifdef HEX_TX_CRLF_EN
      c_st_digit: if (w_xfer && w_last) state_d = c_st_cr;
      c_st_cr:    if (w_xfer) state_d = c_st_lf;
      c_st_lf:    if (w_xfer) state_d = c_st_idle;
`else
      c_st_digit: if (w_xfer && w_last) state_d = c_st_idle;
`endif
      default:    state_d = c_st_idle;
    endcase
  end

  // Datapath: load the word on accept, then preload the next character on each transfer.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    valid_d = valid_q;
    if (w_accept) begin
      shreg_d = w_ext;
      cnt_d   = CNT_W'(NUM_DIGITS - 1);
      char_d  = nib_to_ascii(w_ext[SHIFT_W-1 -: 4]);
      valid_d = 1'b1;
    end else if (w_xfer) begin
      case (state_q)
        c_st_digit: begin
          if (w_last) begin
`ifdef HEX_TX_CRLF_EN
            char_d  = 8'h0D;
            valid_d = 1'b1;
`else
            char_d  = 8'h00;
            valid_d = 1'b0;
`endif
          end else begin
            shreg_d = w_shifted;
            cnt_d   = cnt_q - 1'b1;
            char_d  = nib_to_ascii(w_shifted[SHIFT_W-1 -: 4]);
          end
        end
`ifdef HEX_TX_CRLF_EN
        c_st_cr: char_d = 8'h0A;
        c_st_lf: begin
          char_d  = 8'h00;
          valid_d = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs: ready/busy follow the state, the byte stream comes straight from flops.
  always_comb begin
    oREADY = (state_q == c_st_idle);
    oBUSY  = (state_q != c_st_idle);
    oVALID = valid_q;
    oD     = char_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_ascii_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_ascii_tx_encoder
// Purpose  : Self-checking bench for hex_ascii_tx_encoder. Three instances
//            (16-bit upper, 16-bit lower, 10-bit upper) are checked every
//            cycle against a queue-of-characters model; directed words pin
//            the model with literal character sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_ascii_tx_encoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       iv  [3];
  logic [15:0] idd [3];
  logic       ir  [3];
  logic       ov  [3];
  logic       ordy[3];
  logic       obusy[3];
  logic [7:0] od  [3];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int log_sel  = 0;
  logic [7:0] logq[$];
  logic [7:0] exp_l[$];

  always #5 CLK = ~CLK;

  hex_ascii_tx_encoder #(.DATA_WIDTH(16), .UPPER_CASE(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .iVALID(iv[0]), .iD(idd[0]), .oREADY(ordy[0]),
    .oVALID(ov[0]), .oD(od[0]), .iREADY(ir[0]), .oBUSY(obusy[0]));

  hex_ascii_tx_encoder #(.DATA_WIDTH(16), .UPPER_CASE(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .iVALID(iv[1]), .iD(idd[1]), .oREADY(ordy[1]),
    .oVALID(ov[1]), .oD(od[1]), .iREADY(ir[1]), .oBUSY(obusy[1]));

  hex_ascii_tx_encoder #(.DATA_WIDTH(10), .UPPER_CASE(1'b1)) dut_c (
    .CLK(CLK), .RST(RST), .iVALID(iv[2]), .iD(idd[2][9:0]), .oREADY(ordy[2]),
    .oVALID(ov[2]), .oD(od[2]), .iREADY(ir[2]), .oBUSY(obusy[2]));

  // Characters per word, including the optional terminator.
  function automatic int nchars(input int nd);
`ifdef HEX_TX_CRLF_EN
    return nd + 2;
`else
    return nd;
`endif
  endfunction

  // Character number idx of a word: hex digits MSB first, then CR, LF.
  function automatic logic [7:0] get_char(input logic [15:0] d, input int nd,
                                          input bit uc, input int idx);
    logic [7:0] n;
    if (idx == nd)     return 8'h0D;
    if (idx == nd + 1) return 8'h0A;
    n = 8'((d >> (4 * (nd - 1 - idx))) & 16'hF);
    if (n < 8'd10) return 8'h30 + n;
    return (uc ? 8'h41 : 8'h61) + n - 8'd10;
  endfunction

  // Model: queue of characters still owed by each encoder.
  for (genvar g = 0; g < 3; g++) begin : g_model
    localparam int DW = (g == 2) ? 10 : 16;
    localparam bit UC = (g == 1) ? 1'b0 : 1'b1;
    localparam int ND = (DW + 3) / 4;
    logic [7:0] q[$];
    logic       e_valid = 1'b0;
    logic [7:0] e_d     = 8'h00;
    always @(posedge CLK) begin : p_model
      logic [15:0] dm;
      if (RST) begin
        q.delete();
      end else if (q.size() != 0) begin
        if (ir[g]) void'(q.pop_front());
      end else if (iv[g]) begin
        dm = idd[g] & 16'((1 << DW) - 1);
        for (int i = 0; i < nchars(ND); i++) q.push_back(get_char(dm, ND, UC, i));
      end
      e_valid = (q.size() != 0);
      e_d     = e_valid ? q[0] : 8'h00;
    end
  end

  task automatic cmp(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic check_one(input int k, input logic ev, input logic [7:0] ed);
    cmp("oVALID", k, 32'(ov[k]), 32'(ev));
    cmp("oREADY", k, 32'(ordy[k]), 32'(!ev));
    cmp("oBUSY", k, 32'(obusy[k]), 32'(ev));
    if (ev) cmp("oD", k, 32'(od[k]), 32'(ed));
  endtask

  // Compare all instances against the model every cycle; log transfers of the selected one.
  always @(negedge CLK) begin
    if (chk_en) begin
      check_one(0, g_model[0].e_valid, g_model[0].e_d);
      check_one(1, g_model[1].e_valid, g_model[1].e_d);
      check_one(2, g_model[2].e_valid, g_model[2].e_d);
      if (!RST && ov[log_sel] && ir[log_sel]) logq.push_back(od[log_sel]);
    end
  end

  task automatic add_crlf();
`ifdef HEX_TX_CRLF_EN
    exp_l.push_back(8'h0D);
    exp_l.push_back(8'h0A);
`endif
  endtask

  task automatic check_log(input string name);
    cmp({name, "_len"}, log_sel, 32'(logq.size()), 32'(exp_l.size()));
    for (int i = 0; i < logq.size() && i < exp_l.size(); i++)
      cmp(name, log_sel, 32'(logq[i]), 32'(exp_l[i]));
    logq.delete();
  endtask

  task automatic wait_ready(input int k);
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (ordy[k]) return;
    end
    cmp("ready_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic send(input int k, input logic [15:0] d);
    @(posedge CLK); #1;
    iv[k]  = 1'b1;
    idd[k] = d;
    wait_ready(k);
    @(posedge CLK); #1;
    iv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (!obusy[k]) return;
    end
    cmp("idle_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string name);
    @(negedge CLK); #1;
    cmp({name, "_oVALID"}, 0, 32'(ov[0]), 32'd0);
    cmp({name, "_oD"}, 0, 32'(od[0]), 32'h00);
    cmp({name, "_oREADY"}, 0, 32'(ordy[0]), 32'd1);
    cmp({name, "_oBUSY"}, 0, 32'(obusy[0]), 32'd0);
  endtask

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    int pat[7];
    pat = '{1, 0, 0, 1, 0, 1, 1};
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; idd[k] = 16'h0000; ir[k] = 1'b1;
    end
    // A word offered during reset must be ignored.
    iv[0] = 1'b1; idd[0] = 16'hFFFF;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0; iv[0] = 1'b0;
    chk_en = 1'b1;
    check_reset_state("reset");

    // Basic word at full throughput.
    log_sel = 0; logq.delete();
    send(0, 16'h1A3F); wait_idle(0);
    exp_l = '{8'h31, 8'h41, 8'h33, 8'h46}; add_crlf();
    check_log("w1A3F");

    // Stalls with an irregular iREADY pattern.
    @(posedge CLK); #1;
    send(0, 16'h1234);
    for (int j = 0; j < 7; j++) begin
      ir[0] = pat[j][0];
      @(posedge CLK); #1;
    end
    ir[0] = 1'b1;
    wait_idle(0);
    exp_l = '{8'h31, 8'h32, 8'h33, 8'h34}; add_crlf();
    check_log("stall1234");

    // Next word held on iVALID while busy is taken only after the previous one ends.
    @(posedge CLK); #1;
    iv[0] = 1'b1; idd[0] = 16'hFFFF;
    wait_ready(0);
    @(posedge CLK); #1;
    idd[0] = 16'h0000;
    wait_ready(0);
    @(posedge CLK); #1;
    iv[0] = 1'b0;
    wait_idle(0);
    exp_l = '{8'h46, 8'h46, 8'h46, 8'h46}; add_crlf();
    for (int j = 0; j < 4; j++) exp_l.push_back(8'h30);
    add_crlf();
    check_log("held_iv");

    // Reset in the middle of a word discards it.
    @(posedge CLK); #1;
    send(0, 16'hC0DE);
    for (int n = 0; n < 50 && logq.size() < 2; n++) begin
      @(negedge CLK); #1;
    end
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    check_reset_state("midreset");
    exp_l = '{8'h43, 8'h30};
    check_log("pre_reset");
    send(0, 16'hFFFF); wait_idle(0);
    exp_l = '{8'h46, 8'h46, 8'h46, 8'h46}; add_crlf();
    check_log("post_reset");

    // Lower-case instance.
    log_sel = 1; logq.delete();
    send(1, 16'hBEEF); wait_idle(1);
    exp_l = '{8'h62, 8'h65, 8'h65, 8'h66}; add_crlf();
    check_log("lcBEEF");

    // 10-bit instance: three digits, MSB digit zero-padded.
    log_sel = 2; logq.delete();
    send(2, 16'h03FF); wait_idle(2);
    exp_l = '{8'h33, 8'h46, 8'h46}; add_crlf();
    check_log("w3FF");
    log_sel = 0;

    // Randomised traffic, back-pressure and occasional resets on all instances.
    for (int c = 0; c < 1500; c++) begin
      @(posedge CLK); #1;
      for (int k = 0; k < 3; k++) begin
        iv[k]  = ($urandom % 3) == 0;
        idd[k] = 16'($urandom);
        ir[k]  = ($urandom % 4) != 0;
      end
      RST = ($urandom % 150) == 0;
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ir[k] = 1'b1;
    end
    for (int k = 0; k < 3; k++) wait_idle(k);
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
